// File: rtl/d7s_pkg.sv
// Shared types and constants for the multiplexed
// seven-segment scan controller.
package d7s_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        ON    = 2'd2
    } state_t;

    // Segment patterns {g,f,e,d,c,b,a} for hex 0..F.
    localparam logic [6:0] HEX7 [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F,
        7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C,
        7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic int idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/d7s_scan_ctrl_hex_to_seg7.sv
// Combinational hex nibble to seven-segment decoder.
// Active-high segments, seg[0] is segment a.
module hex_to_seg7
    import d7s_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    assign seg = HEX7[nib];

endmodule

// File: rtl/d7s_scan_ctrl.sv
// Scan scheduler for a multiplexed seven-segment display
// with frame-aligned commit of new display values.
module d7s_scan_ctrl
    import d7s_pkg::*;
#(
    parameter int NUM_DIGITS = 3,
    parameter int SCAN_DIV   = 10000,
    parameter int BLANK_CYC  = 16,
    parameter int CNT_W      = 16,
    parameter int IW         = idx_w(NUM_DIGITS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    load_valid,
    input  logic [4*NUM_DIGITS-1:0] load_data,
    output logic                    load_ready,
    output logic [NUM_DIGITS-1:0]   digit_sel,
    output logic [6:0]              seg,
    output logic [IW-1:0]           digit_idx,
    output logic                    frame_done
);

    localparam logic [CNT_W-1:0] ON_LAST =
        CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST =
        (BLANK_CYC > 0) ? CNT_W'(BLANK_CYC - 1) : '0;

    state_t                  state;
    logic [CNT_W-1:0]        timer;
    logic [4*NUM_DIGITS-1:0] active;
    logic [4*NUM_DIGITS-1:0] shadow;
    logic                    pending;

    logic                    on_end;
    logic                    last;
    logic                    accept;
    logic                    commit;
    logic [IW-1:0]           idx_nx;
    logic [4*NUM_DIGITS-1:0] act_nx;
    logic [3:0]              nib;
    logic [NUM_DIGITS-1:0]   sel_nx;
    logic [6:0]              seg_nx;

    assign load_ready = !pending;

    // Next-slot index and display value, so seg and
    // digit_sel are loaded together on the entry edge.
    always_comb begin
        on_end = (state == ON) && (timer == ON_LAST);
        last   = (digit_idx == IW'(NUM_DIGITS - 1));
        accept = load_valid && !pending;
        commit = pending &&
                 ((state == IDLE) || (en && on_end && last));
        idx_nx = digit_idx;
        if (state == IDLE)
            idx_nx = '0;
        else if (on_end)
            idx_nx = last ? '0 : digit_idx + IW'(1);
        act_nx = commit ? shadow : active;
        nib = '0;
        for (int i = 0; i < NUM_DIGITS; i++)
            if (idx_nx == IW'(i))
                nib = act_nx[4*i +: 4];
        sel_nx = NUM_DIGITS'(1) << idx_nx;
    end

    hex_to_seg7 u_dec (
        .nib (nib),
        .seg (seg_nx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            timer      <= '0;
            digit_idx  <= '0;
            digit_sel  <= '0;
            seg        <= '0;
            frame_done <= 1'b0;
            active     <= '0;
            shadow     <= '0;
            pending    <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (accept) begin
                shadow  <= load_data;
                pending <= 1'b1;
            end
            if (commit) begin
                active  <= act_nx;
                pending <= 1'b0;
            end
            unique case (state)
                IDLE: begin
                    digit_sel <= '0;
                    seg       <= '0;
                    digit_idx <= '0;
                    timer     <= '0;
                    if (en) begin
                        if (BLANK_CYC == 0) begin
                            state     <= ON;
                            digit_sel <= sel_nx;
                            seg       <= seg_nx;
                        end else begin
                            state <= BLANK;
                        end
                    end
                end
                BLANK: begin
                    if (!en) begin
                        state     <= IDLE;
                        digit_idx <= '0;
                        timer     <= '0;
                    end else if (timer == BLANK_LAST) begin
                        state     <= ON;
                        timer     <= '0;
                        digit_sel <= sel_nx;
                        seg       <= seg_nx;
                    end else begin
                        timer <= timer + CNT_W'(1);
                    end
                end
                ON: begin
                    if (!en) begin
                        state     <= IDLE;
                        digit_sel <= '0;
                        seg       <= '0;
                        digit_idx <= '0;
                        timer     <= '0;
                    end else if (on_end) begin
                        timer     <= '0;
                        digit_idx <= idx_nx;
                        if (last)
                            frame_done <= 1'b1;
                        if (BLANK_CYC == 0) begin
                            digit_sel <= sel_nx;
                            seg       <= seg_nx;
                        end else begin
                            state     <= BLANK;
                            digit_sel <= '0;
                            seg       <= '0;
                        end
                    end else begin
                        timer <= timer + CNT_W'(1);
                    end
                end
                default: begin
                    state     <= IDLE;
                    digit_sel <= '0;
                    seg       <= '0;
                    digit_idx <= '0;
                    timer     <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_d7s_scan_ctrl.sv
// Scoreboard bench for d7s_scan_ctrl: expected display
// slots are queued, a monitor checks each ON slot.
module tb_d7s_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        load_valid;
    logic [11:0] load_data;
    logic        load_ready;
    logic [2:0]  digit_sel;
    logic [6:0]  seg;
    logic [1:0]  digit_idx;
    logic        frame_done;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct packed {
        logic [2:0] sel;
        logic [6:0] seg;
        logic [1:0] idx;
    } slot_t;

    slot_t      exp_q[$];
    logic [2:0] prev_sel = 3'b000;

    d7s_scan_ctrl #(
        .NUM_DIGITS (3),
        .SCAN_DIV   (4),
        .BLANK_CYC  (2),
        .CNT_W      (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (load_ready),
        .digit_sel  (digit_sel),
        .seg        (seg),
        .digit_idx  (digit_idx),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: each new lit digit is one DUT output slot.
    always @(negedge clk) begin
        if (digit_sel != 3'b000 && digit_sel != prev_sel) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL slot unexpected sel=%b seg=%h",
                         digit_sel, seg);
            end else begin
                slot_t e;
                e = exp_q.pop_front();
                if ({digit_sel, seg, digit_idx} !== e) begin
                    errors++;
                    $display("FAIL slot actual=%b/%h/%0d required=%b/%h/%0d",
                             digit_sel, seg, digit_idx,
                             e.sel, e.seg, e.idx);
                end
            end
        end
        prev_sel <= digit_sel;
    end

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h",
                     name, act, req);
        end
    endtask

    task automatic push(input logic [6:0] s0,
                        input logic [6:0] s1,
                        input logic [6:0] s2);
        exp_q.push_back('{3'b001, s0, 2'd0});
        exp_q.push_back('{3'b010, s1, 2'd1});
        exp_q.push_back('{3'b100, s2, 2'd2});
    endtask

    task automatic wait_fd(output int at);
        bit done = 1'b0;
        at = 0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (frame_done === 1'b1) begin
                done = 1'b1;
                at   = cyc;
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL wait_fd timeout actual=0 required=1");
        end
    endtask

    task automatic wait_sel(input logic [2:0] s);
        bit done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (digit_sel === s)
                done = 1'b1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL wait_sel timeout actual=%b required=%b",
                     digit_sel, s);
        end
    endtask

    initial begin
        int  fd1, fd2, t;
        bit  flag;
        rst        = 1'b1;
        en         = 1'b0;
        load_valid = 1'b0;
        load_data  = '0;
        repeat (2) @(negedge clk);
        chk("rst_sel",   32'(digit_sel),  0);
        chk("rst_seg",   32'(seg),        0);
        chk("rst_idx",   32'(digit_idx),  0);
        chk("rst_fd",    32'(frame_done), 0);
        chk("rst_ready", 32'(load_ready), 1);

        // Free run with an all-zero display.
        rst = 1'b0;
        push(7'h3F, 7'h3F, 7'h3F);
        push(7'h3F, 7'h3F, 7'h3F);
        en = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("blank_sel", 32'(digit_sel), 0);
        end
        @(negedge clk);
        chk("first_sel", 32'(digit_sel), 1);
        chk("first_seg", 32'(seg), 32'h3F);
        wait_fd(fd1);
        wait_fd(fd2);
        chk("frame_period", 32'(fd2 - fd1), 18);
        en = 1'b0;

        // Load while idle, commits on the next edge.
        @(negedge clk);
        chk("idle_ready", 32'(load_ready), 1);
        load_valid = 1'b1;
        load_data  = 12'h321;
        @(negedge clk);
        chk("ready_drop", 32'(load_ready), 0);
        load_valid = 1'b0;
        @(negedge clk);
        chk("ready_back", 32'(load_ready), 1);
        push(7'h06, 7'h5B, 7'h4F);
        en = 1'b1;
        wait_fd(t);
        en = 1'b0;

        // Mid-frame load, then a stalled second load.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        push(7'h3F, 7'h3F, 7'h3F);
        push(7'h7F, 7'h77, 7'h71);
        exp_q.push_back('{3'b001, 7'h6D, 2'd0});
        exp_q.push_back('{3'b010, 7'h6D, 2'd1});
        en = 1'b1;
        wait_sel(3'b010);
        load_valid = 1'b1;
        load_data  = 12'hFA8;
        @(negedge clk);
        chk("ready_accept", 32'(load_ready), 0);
        load_data = 12'h555;
        flag = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (frame_done === 1'b1)
                break;
            if (load_ready !== 1'b0)
                flag = 1'b1;
        end
        chk("ready_held_low", 32'(flag), 0);
        chk("fd_commit",      32'(frame_done), 1);
        chk("ready_commit",   32'(load_ready), 1);
        @(negedge clk);
        chk("second_accept", 32'(load_ready), 0);
        load_valid = 1'b0;
        wait_fd(t);
        chk("second_commit", 32'(load_ready), 1);

        // Drop en during digit1 ON.
        wait_sel(3'b010);
        en = 1'b0;
        @(negedge clk);
        chk("off_sel", 32'(digit_sel),  0);
        chk("off_seg", 32'(seg),        0);
        chk("off_idx", 32'(digit_idx),  0);
        chk("off_fd",  32'(frame_done), 0);
        flag = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (frame_done !== 1'b0 || digit_sel !== 3'b000)
                flag = 1'b1;
        end
        chk("off_quiet", 32'(flag), 0);
        exp_q.push_back('{3'b001, 7'h6D, 2'd0});
        en = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("re_blank", 32'(digit_sel), 0);
        end
        @(negedge clk);
        chk("re_sel", 32'(digit_sel), 1);
        chk("re_seg", 32'(seg), 32'h6D);

        // Reset during ON with an update pending.
        load_valid = 1'b1;
        load_data  = 12'h123;
        @(negedge clk);
        chk("pend_ready", 32'(load_ready), 0);
        rst        = 1'b1;
        load_valid = 1'b0;
        @(negedge clk);
        chk("mid_rst_sel",   32'(digit_sel),  0);
        chk("mid_rst_seg",   32'(seg),        0);
        chk("mid_rst_idx",   32'(digit_idx),  0);
        chk("mid_rst_fd",    32'(frame_done), 0);
        chk("mid_rst_ready", 32'(load_ready), 1);
        push(7'h3F, 7'h3F, 7'h3F);
        rst = 1'b0;
        wait_fd(t);
        en = 1'b0;
        repeat (3) @(negedge clk);
        chk("queue_empty", 32'(exp_q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
